// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the multimode counter: mode encodings and step sizes.
// The datapath and the display decoder import the same package.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_UP1      = 2'd0,
    MODE_DOWN1    = 2'd1,
    MODE_UP2      = 2'd2,
    MODE_PINGPONG = 2'd3
  } mode_e;

  localparam logic [1:0] STEP_1 = 2'd1;
  localparam logic [1:0] STEP_2 = 2'd2;

  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
// Holds its count while disabled; restart forces it back to 0.
module tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // A restart on the wrap edge swallows that tick.
  assign tick = enable & ~restart & (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset || restart) cnt <= '0;
    else if (enable)      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/multimode_count_ctrl.sv
// Sequencing controller for the multimode counter: paces step strobes, picks
// direction/magnitude per mode and issues clears on every mode change.
module multimode_count_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mode_btn,
  input  logic             pause_btn,
  input  logic [WIDTH-1:0] count_in,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic [1:0]       cnt_step,
  output logic             cnt_clear,
  output logic [1:0]       mode,
  output logic             running
);

  localparam logic [WIDTH-1:0] MAX = '1;

  mode_e      mode_q, mode_d;
  logic       running_d;
  logic       dir_q, dir_d;
  logic       up_d;
  logic [1:0] step_d;
  logic       tick;

  // Pausing on a wrap edge freezes the divider at its last count, so the
  // strobe comes one edge after resume.
  tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
    .clock   (clock),
    .reset   (reset),
    .restart (mode_btn),
    .enable  (running & ~pause_btn),
    .tick    (tick)
  );

  always_comb begin
    mode_d    = mode_q;
    running_d = running;
    dir_d     = dir_q;
    up_d      = cnt_up;
    step_d    = cnt_step;
    if (tick) begin
      step_d = (mode_q == MODE_UP2) ? STEP_2 : STEP_1;
      case (mode_q)
        MODE_UP1, MODE_UP2: up_d = 1'b1;
        MODE_DOWN1:         up_d = 1'b0;
        MODE_PINGPONG: begin
          if (dir_q && count_in == MAX)        dir_d = 1'b0;
          else if (!dir_q && count_in == '0)   dir_d = 1'b1;
          up_d = dir_d;
        end
        default:            up_d = 1'b1;
      endcase
    end
    if (mode_btn) begin
      mode_d = next_mode(mode_q);
      dir_d  = 1'b1;
    end
    if (pause_btn) running_d = ~running;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q    <= MODE_UP1;
      running   <= 1'b1;
      dir_q     <= 1'b1;
      cnt_en    <= 1'b0;
      cnt_clear <= 1'b0;
      cnt_up    <= 1'b1;
      cnt_step  <= STEP_1;
    end else begin
      mode_q    <= mode_d;
      running   <= running_d;
      dir_q     <= dir_d;
      cnt_en    <= tick;
      cnt_clear <= mode_btn;
      cnt_up    <= up_d;
      cnt_step  <= step_d;
    end
  end

  assign mode = mode_q;

endmodule
